carfield_regbus_decode_resp: RTL and testbench

Registered RegBus address decoder and error responder between the host-side RegBus port and the RegBus peripheral targets (register file, PLL, padframe, L2 ECC). It holds the host request, decodes the address against per-target base/size windows, forwards it to the one matching enabled target, and returns that target's response. Unmapped or disabled addresses, and targets that stall past a timeout, get a deterministic error response, so a bad access can never hang the host.

---
 rtl/carfield_regbus_decode_resp.sv | 140 ++++++++++++++
 tb/tb_carfield_regbus_decode_resp.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/carfield_regbus_decode_resp.sv
// Registered RegBus decoder/error responder: one request in flight, per-target base/size windows,
// deterministic error on decode miss or target timeout. Optional error counter: CARFIELD_REGBUS_ERRCNT_EN.
module carfield_regbus_decode_resp #(
  parameter int unsigned                 NumTgt        = 4,
  parameter int unsigned                 AddrWidth     = 48,
  parameter int unsigned                 DataWidth     = 32,
  parameter logic [NumTgt*AddrWidth-1:0] TgtBase       = '0,
  parameter logic [NumTgt*AddrWidth-1:0] TgtSize       = '0,
  parameter int unsigned                 TimeoutCycles = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  input  logic                        req_write_i,
  input  logic [AddrWidth-1:0]        req_addr_i,
  input  logic [DataWidth-1:0]        req_wdata_i,
  input  logic [DataWidth/8-1:0]      req_wstrb_i,
  output logic                        rsp_ready_o,
  output logic [DataWidth-1:0]        rsp_rdata_o,
  output logic                        rsp_error_o,
  input  logic [NumTgt-1:0]           tgt_enable_i,
  output logic [NumTgt-1:0]           tgt_valid_o,
  output logic                        tgt_write_o,
  output logic [AddrWidth-1:0]        tgt_addr_o,
  output logic [DataWidth-1:0]        tgt_wdata_o,
  output logic [DataWidth/8-1:0]      tgt_wstrb_o,
  input  logic [NumTgt-1:0]           tgt_ready_i,
  input  logic [NumTgt*DataWidth-1:0] tgt_rdata_i,
  input  logic [NumTgt-1:0]           tgt_error_i,
  output logic [15:0]                 err_count_o
);

  localparam int unsigned SelWidth = (NumTgt > 1) ? $clog2(NumTgt) : 1;
  localparam int unsigned CntWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FWD  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]          state;
  logic [SelWidth-1:0] sel;
  logic [CntWidth-1:0] tmo_cnt;
  logic                hit;
  logic [SelWidth-1:0] hit_sel;

  // Descending scan so the lowest matching index is the one left standing.
  // Offset-vs-size compare avoids overflow of base+size at the top of the map.
  always_comb begin
    hit     = 1'b0;
    hit_sel = '0;
    for (int i = int'(NumTgt) - 1; i >= 0; i--) begin
      if (tgt_enable_i[i] &&
          (req_addr_i >= TgtBase[i*AddrWidth +: AddrWidth]) &&
          ((req_addr_i - TgtBase[i*AddrWidth +: AddrWidth]) < TgtSize[i*AddrWidth +: AddrWidth])) begin
        hit     = 1'b1;
        hit_sel = SelWidth'(i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      sel         <= '0;
      tmo_cnt     <= '0;
      rsp_ready_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
      tgt_valid_o <= '0;
      tgt_write_o <= 1'b0;
      tgt_addr_o  <= '0;
      tgt_wdata_o <= '0;
      tgt_wstrb_o <= '0;
    end else begin
      rsp_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            tgt_write_o <= req_write_i;
            tgt_addr_o  <= req_addr_i;
            tgt_wdata_o <= req_wdata_i;
            tgt_wstrb_o <= req_wstrb_i;
            if (hit) begin
              sel         <= hit_sel;
              tgt_valid_o <= NumTgt'(1) << hit_sel;
              tmo_cnt     <= '0;
              state       <= FWD;
            end else begin
              rsp_error_o <= 1'b1;
              rsp_rdata_o <= '0;
              rsp_ready_o <= 1'b1;
              state       <= RESP;
            end
          end
        end
        FWD: begin
          // Ready takes priority over a timeout landing in the same cycle.
          if (tgt_ready_i[sel]) begin
            rsp_rdata_o <= tgt_rdata_i[sel*DataWidth +: DataWidth];
            rsp_error_o <= tgt_error_i[sel];
            rsp_ready_o <= 1'b1;
            tgt_valid_o <= '0;
            state       <= RESP;
          end else if (tmo_cnt == CntWidth'(TimeoutCycles - 1)) begin
            rsp_rdata_o <= '0;
            rsp_error_o <= 1'b1;
            rsp_ready_o <= 1'b1;
            tgt_valid_o <= '0;
            state       <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CARFIELD_REGBUS_ERRCNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] err_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_count <= '0;
    end else if (rsp_ready_o && rsp_error_o) begin
      err_count <= sat_inc(err_count);
    end
  end

  assign err_count_o = err_count;
`else
  assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_carfield_regbus_decode_resp.sv
// Directed-vector bench for carfield_regbus_decode_resp with the four-target test map.
module tb_carfield_regbus_decode_resp;

  localparam int NT = 4;
  localparam int AW = 48;
  localparam int DW = 32;
  localparam logic [NT*AW-1:0] BASES = {48'h200B_0000, 48'h200A_0000, 48'h2002_0000, 48'h2001_0000};
  localparam logic [NT*AW-1:0] SIZES = {4{48'h0000_1000}};

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            req_valid_i;
  logic            req_write_i;
  logic [AW-1:0]   req_addr_i;
  logic [DW-1:0]   req_wdata_i;
  logic [DW/8-1:0] req_wstrb_i;
  logic            rsp_ready_o;
  logic [DW-1:0]   rsp_rdata_o;
  logic            rsp_error_o;
  logic [NT-1:0]   tgt_enable_i;
  logic [NT-1:0]   tgt_valid_o;
  logic            tgt_write_o;
  logic [AW-1:0]   tgt_addr_o;
  logic [DW-1:0]   tgt_wdata_o;
  logic [DW/8-1:0] tgt_wstrb_o;
  logic [NT-1:0]   tgt_ready_i;
  logic [NT*DW-1:0] tgt_rdata_i;
  logic [NT-1:0]   tgt_error_i;
  logic [15:0]     err_count_o;

  int nvec = 0;
  int nerr = 0;
  int exp_errs = 0;

  carfield_regbus_decode_resp #(
    .NumTgt(NT), .AddrWidth(AW), .DataWidth(DW),
    .TgtBase(BASES), .TgtSize(SIZES), .TimeoutCycles(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .rsp_ready_o(rsp_ready_o), .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
    .tgt_enable_i(tgt_enable_i), .tgt_valid_o(tgt_valid_o), .tgt_write_o(tgt_write_o),
    .tgt_addr_o(tgt_addr_o), .tgt_wdata_o(tgt_wdata_o), .tgt_wstrb_o(tgt_wstrb_o),
    .tgt_ready_i(tgt_ready_i), .tgt_rdata_i(tgt_rdata_i), .tgt_error_i(tgt_error_i),
    .err_count_o(err_count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt();
`ifdef CARFIELD_REGBUS_ERRCNT_EN
    return 16'(exp_errs);
`else
    return 16'h0;
`endif
  endfunction

  // Starts on a negedge; cycle 0 is the one ending at the next posedge.
  // rdy_at = FWD-relative cycle where the target answers (0 = never).
  task automatic xfer(input string tag, input logic wr, input logic [AW-1:0] addr,
                      input logic [NT-1:0] exp_vld, input int rdy_at,
                      input logic [DW-1:0] rdat, input logic terr, input int exp_lat,
                      input logic [DW-1:0] exp_rdata, input logic exp_err);
    logic [DW-1:0] wd;
    wd = 32'h1111_2222 ^ addr[31:0];
    req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr;
    req_wdata_i = wd; req_wstrb_i = 4'b1011;
    tgt_ready_i = '0; tgt_error_i = '0; tgt_rdata_i = {NT{32'hDEAD_BEEF}};
    for (int cyc = 1; cyc <= exp_lat; cyc++) begin
      @(posedge clk_i); @(negedge clk_i);
      tgt_ready_i = '0; tgt_error_i = '0; tgt_rdata_i = {NT{32'hDEAD_BEEF}};
      if (cyc < exp_lat) begin
        chk({tag, "_vld"}, 64'(tgt_valid_o), 64'(exp_vld));
        chk({tag, "_nrsp"}, 64'(rsp_ready_o), 64'd0);
        if (cyc == 1) begin
          chk({tag, "_addr"}, 64'(tgt_addr_o), 64'(addr));
          chk({tag, "_wr"}, 64'({tgt_write_o, tgt_wstrb_o, tgt_wdata_o}), 64'({wr, 4'b1011, wd}));
        end
        if (cyc == rdy_at) begin
          tgt_ready_i = exp_vld;
          tgt_error_i = terr ? exp_vld : '0;
          for (int j = 0; j < NT; j++)
            if (exp_vld[j]) tgt_rdata_i[j*DW +: DW] = rdat;
        end
      end else begin
        chk({tag, "_rsp"}, 64'(rsp_ready_o), 64'd1);
        chk({tag, "_rdata"}, 64'(rsp_rdata_o), 64'(exp_rdata));
        chk({tag, "_err"}, 64'(rsp_error_o), 64'(exp_err));
        chk({tag, "_vldoff"}, 64'(tgt_valid_o), 64'd0);
      end
    end
    req_valid_i = 1'b0;
    if (exp_err) exp_errs++;
    @(posedge clk_i); @(negedge clk_i);
    chk({tag, "_rspoff"}, 64'(rsp_ready_o), 64'd0);
    chk({tag, "_ecnt"}, 64'(err_count_o), 64'(exp_cnt()));
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0;
    req_wdata_i = '0; req_wstrb_i = '0; tgt_enable_i = 4'b1111;
    tgt_ready_i = '0; tgt_rdata_i = '0; tgt_error_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_rsp", 64'({rsp_ready_o, rsp_error_o, tgt_valid_o}), 64'd0);
    chk("rst_data", 64'(rsp_rdata_o), 64'd0);
    chk("rst_req", 64'({tgt_write_o, tgt_wstrb_o, tgt_addr_o}), 64'd0);
    chk("rst_wdata", 64'(tgt_wdata_o), 64'd0);
    chk("rst_ecnt", 64'(err_count_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    xfer("rd_t1", 1'b0, 48'h2002_0010, 4'b0010, 1, 32'hCAFE_F00D, 1'b0, 2, 32'hCAFE_F00D, 1'b0);
    xfer("wr_unmap", 1'b1, 48'h2003_0000, 4'b0000, 0, 32'h0, 1'b0, 1, 32'h0, 1'b1);
    xfer("tmo_t3", 1'b0, 48'h200B_0FFC, 4'b1000, 0, 32'h0, 1'b0, 9, 32'h0, 1'b1);
    xfer("late_t3", 1'b0, 48'h200B_0FFC, 4'b1000, 8, 32'hA5A5_5A5A, 1'b0, 9, 32'hA5A5_5A5A, 1'b0);
    xfer("terr_t0", 1'b1, 48'h2001_0FFF, 4'b0001, 2, 32'h0BAD_0BAD, 1'b1, 3, 32'h0BAD_0BAD, 1'b1);
    xfer("rd_t2", 1'b0, 48'h200A_0004, 4'b0100, 1, 32'h1234_5678, 1'b0, 2, 32'h1234_5678, 1'b0);

    tgt_enable_i = 4'b1011;
    xfer("dis_lo", 1'b0, 48'h200A_0000, 4'b0000, 0, 32'h0, 1'b0, 1, 32'h0, 1'b1);
    xfer("dis_hi", 1'b0, 48'h200A_0FFF, 4'b0000, 0, 32'h0, 1'b0, 1, 32'h0, 1'b1);
    xfer("past_t0", 1'b0, 48'h2001_1000, 4'b0000, 0, 32'h0, 1'b0, 1, 32'h0, 1'b1);
    tgt_enable_i = 4'b1111;

    // Abort an access in FWD with reset.
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 48'h2001_0000;
    @(posedge clk_i); @(negedge clk_i);
    chk("abort_vld", 64'(tgt_valid_o), 64'b0001);
    rst_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 1'b0; req_valid_i = 1'b0; exp_errs = 0;
    chk("abort_clr", 64'({rsp_ready_o, tgt_valid_o, tgt_addr_o}), 64'd0);
    chk("abort_ecnt", 64'(err_count_o), 64'd0);
    tgt_ready_i = 4'b1111;
    @(posedge clk_i); @(negedge clk_i);
    chk("abort_norsp", 64'({rsp_ready_o, tgt_valid_o}), 64'd0);
    xfer("post_rst", 1'b0, 48'h2001_0000, 4'b0001, 1, 32'h600D_CAFE, 1'b0, 2, 32'h600D_CAFE, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
